// File: rtl/pdm_pkg.sv
// Shared types and defaults for the PDM microphone capture path.
package pdm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAKE = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    STOP = 3'd4
  } pdm_state_t;

  localparam int PCM_W          = 16;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_WAKE_CYC   = 1024;
  localparam int DEF_WARMUP     = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  // Bits are only handed to the decimator while it is out of clear.
  function automatic logic is_capture(pdm_state_t s);
    return (s == WARM) || (s == RUN);
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Small synchronous FIFO for PCM samples; a pop on a full FIFO frees the slot for a same-cycle push.
module pcm_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM mic clock generator, bit capture and decimator pacing, with a PCM output FIFO.
// Define PDM_OVF_CNT_EN to add the saturating dropped-sample counter ovf_count.
//
// state | meaning
// IDLE  | mic clock off, decimator held in clear, FIFO flushed
// WAKE  | mic clock running, waiting WAKE_CYC periods for the mic to settle
// WARM  | capturing; first WARMUP decimator outputs discarded
// RUN   | capturing; decimator outputs written to the FIFO
// STOP  | no capture; finishing the current mic clock period
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int WAKE_CYC   = DEF_WAKE_CYC,
  parameter int WARMUP     = DEF_WARMUP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             mic_clk,
  input  logic             pdm_data,
  output logic             dec_rst,
  output logic             dec_ce,
  output logic             dec_x,
  input  logic [PCM_W-1:0] dec_pcm,
  input  logic             dec_valid,
  output logic             dec_ready,
  output logic [PCM_W-1:0] pcm_out,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overflow,
`ifdef PDM_OVF_CNT_EN
  output logic [15:0]      ovf_count,
`endif
  output logic             busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int WK_W  = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam int WM_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [WK_W-1:0]  WAKE_LOAD = WK_W'(WAKE_CYC - 1);
  localparam logic [WM_W-1:0]  WARM_LOAD = WM_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  pdm_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [WK_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [WM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic             mic_clk_q, mic_clk_d;
  logic             dec_rst_q, dec_rst_d;
  logic             dec_ce_q, dec_ce_d;
  logic             dec_x_q, dec_x_d;
  logic             overflow_q, overflow_d;

  logic             div_wrap;
  logic             start;
  logic             fifo_push;
  logic             fifo_clr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  assign div_wrap  = (div_cnt_q == DIV_LAST);
  assign start     = (state_q == IDLE) && enable;
  assign fifo_push = (state_q == RUN) && dec_valid;
  // A full FIFO only drops when the sink is not freeing a slot this cycle.
  assign drop      = fifo_push && fifo_full && !pcm_ready;
  assign fifo_clr  = (state_q == IDLE) || (state_d == IDLE);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = '0;
    wake_cnt_d = wake_cnt_q;
    warm_cnt_d = warm_cnt_q;
    overflow_d = overflow_q;

    if (state_q != IDLE) begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = WAKE;
          wake_cnt_d = WAKE_LOAD;
          overflow_d = 1'b0;
        end
      end
      WAKE: begin
        if (!enable) begin
          state_d = STOP;
        end else if (div_wrap) begin
          if (wake_cnt_q == '0) begin
            state_d    = (WARMUP == 0) ? RUN : WARM;
            warm_cnt_d = WARM_LOAD;
          end else begin
            wake_cnt_d = wake_cnt_q - 1'b1;
          end
        end
      end
      WARM: begin
        if (!enable) begin
          state_d = STOP;
        end else if (dec_valid) begin
          if (warm_cnt_q == '0) begin
            state_d = RUN;
          end else begin
            warm_cnt_d = warm_cnt_q - 1'b1;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (div_wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end

    // Strobe only if capture continues into the next cycle, so leaving RUN never emits a bit.
    dec_ce_d  = is_capture(state_q) && is_capture(state_d) && div_wrap;
    dec_x_d   = (is_capture(state_q) && div_wrap) ? pdm_data : dec_x_q;
    dec_rst_d = !is_capture(state_d);
    mic_clk_d = (state_d != IDLE) && (div_cnt_d < DIV_HALF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      wake_cnt_q <= '0;
      warm_cnt_q <= '0;
      mic_clk_q  <= 1'b0;
      dec_rst_q  <= 1'b1;
      dec_ce_q   <= 1'b0;
      dec_x_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      mic_clk_q  <= mic_clk_d;
      dec_rst_q  <= dec_rst_d;
      dec_ce_q   <= dec_ce_d;
      dec_x_q    <= dec_x_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PDM_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (start) begin
      ovf_cnt_d = '0;
    end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

  pcm_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (PCM_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clr  (fifo_clr),
    .push (fifo_push),
    .pop  (pcm_ready),
    .din  (dec_pcm),
    .dout (pcm_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign mic_clk   = mic_clk_q;
  assign dec_rst   = dec_rst_q;
  assign dec_ce    = dec_ce_q;
  assign dec_x     = dec_x_q;
  assign dec_ready = 1'b1;
  assign pcm_valid = !fifo_empty;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Scoreboard bench for pdm_capture_ctrl with CLK_DIV=4, WAKE_CYC=4, WARMUP=2, FIFO_DEPTH=4.
module tb_pdm_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        mic_clk;
  logic        pdm_data;
  logic        dec_rst;
  logic        dec_ce;
  logic        dec_x;
  logic [15:0] dec_pcm;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        overflow;
`ifdef PDM_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always #5 clk = ~clk;

  pdm_capture_ctrl #(
    .CLK_DIV   (4),
    .WAKE_CYC  (4),
    .WARMUP    (2),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mic_clk  (mic_clk),
    .pdm_data (pdm_data),
    .dec_rst  (dec_rst),
    .dec_ce   (dec_ce),
    .dec_x    (dec_x),
    .dec_pcm  (dec_pcm),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .pcm_out  (pcm_out),
    .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready),
    .overflow (overflow),
`ifdef PDM_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] v);
    dec_valid = 1'b1;
    dec_pcm   = v;
    step();
    dec_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    chk({name, "_drain_left"}, exp_q.size(), 0);
    step();
    chk({name, "_empty_after"}, pcm_valid, 1'b0);
  endtask

  // Monitor: every accepted output word must be the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && pcm_valid && pcm_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got %0h expected none", pcm_out);
      end else begin
        exp_v = exp_q.pop_front();
        if (pcm_out !== exp_v) begin
          errors++;
          $display("FAIL scoreboard_pcm: got %0h expected %0h", pcm_out, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    pdm_data  = 1'b0;
    dec_valid = 1'b0;
    dec_pcm   = 16'h0;
    pcm_ready = 1'b0;
    step(3);

    chk("rst_mic_clk", mic_clk, 1'b0);
    chk("rst_dec_rst", dec_rst, 1'b1);
    chk("rst_dec_ce", dec_ce, 1'b0);
    chk("rst_dec_x", dec_x, 1'b0);
    chk("rst_dec_ready", dec_ready, 1'b1);
    chk("rst_pcm_out", pcm_out, 16'h0);
    chk("rst_pcm_valid", pcm_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);

    reset = 1'b0;
    chk("busy_after_rst_fall", busy, 1'b0);
    step();
    chk("busy_wake", busy, 1'b1);

    // Cycle 0 is the first WAKE cycle; WARM starts at 16, first strobe at 20.
    for (int i = 0; i < 40; i++) begin
      pdm_data = ((i / 4) % 2) == 0;
      chk($sformatf("mic_clk@%0d", i), mic_clk, (i % 4) < 2);
      chk($sformatf("dec_ce@%0d", i), dec_ce, (i >= 20) && (i % 4 == 0));
      chk($sformatf("dec_rst@%0d", i), dec_rst, i < 16);
      if ((i >= 20) && (i % 4 == 0))
        chk($sformatf("dec_x@%0d", i), dec_x, (((i - 1) / 4) % 2) == 0);
      step();
    end

    send(16'hAAAA);
    chk("warm_discard1", pcm_valid, 1'b0);
    step(3);
    send(16'h5555);
    chk("warm_discard2", pcm_valid, 1'b0);
    step(3);

    exp_q.push_back(16'h1234);
    send(16'h1234);
    chk("first_pcm_valid", pcm_valid, 1'b1);
    chk("first_pcm_out", pcm_out, 16'h1234);

    for (int k = 1; k <= 3; k++) begin
      step(2);
      exp_q.push_back(16'(k * 16'h1111));
      send(16'(k * 16'h1111));
    end
    chk("full_no_ovf", overflow, 1'b0);
    step(2);
    send(16'h4444);
    chk("ovf_set", overflow, 1'b1);
`ifdef PDM_OVF_CNT_EN
    chk("ovf_count_1", ovf_count, 16'd1);
`endif
    step(3);
    chk("head_stable", pcm_out, 16'h1234);

    pcm_ready = 1'b1;
    drain("ovf");

    for (int k = 0; k < 10 && !dec_ce; k++) step();
    chk("ce_found", dec_ce, 1'b1);
    step();
    enable = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      chk($sformatf("stop_dec_ce@%0d", j), dec_ce, 1'b0);
      chk($sformatf("stop_busy@%0d", j), busy, j < 2);
      if (j == 2) begin
        chk("idle_dec_rst", dec_rst, 1'b1);
        chk("idle_mic_clk", mic_clk, 1'b0);
        chk("idle_ovf_sticky", overflow, 1'b1);
      end
    end

    pcm_ready = 1'b0;
    enable    = 1'b1;
    step();
    chk("reen_busy", busy, 1'b1);
    chk("reen_ovf_clr", overflow, 1'b0);
`ifdef PDM_OVF_CNT_EN
    chk("reen_ovf_count_clr", ovf_count, 16'd0);
`endif
    step(20);
    send(16'hAAAA);
    step(2);
    send(16'h5555);
    step(2);
    chk("rerun_empty", pcm_valid, 1'b0);

    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(16'hA000 + 16'(k));
      send(16'hA000 + 16'(k));
      step();
    end
    chk("fill2_head", pcm_out, 16'hA001);

    pcm_ready = 1'b1;
    dec_valid = 1'b1;
    dec_pcm   = 16'hA005;
    exp_q.push_back(16'hA005);
    step();
    pcm_ready = 1'b0;
    dec_valid = 1'b0;
    chk("pushpop_full_no_ovf", overflow, 1'b0);
`ifdef PDM_OVF_CNT_EN
    chk("pushpop_ovf_count", ovf_count, 16'd0);
`endif
    chk("pushpop_head", pcm_out, 16'hA002);
    pcm_ready = 1'b1;
    drain("pushpop");

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_dec_rst", dec_rst, 1'b1);
    chk("midrst_mic_clk", mic_clk, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
